// File: rtl/exec_unit.sv
// Execute/writeback stage behind the 16x8 register file: single-cycle ALU ops
// and an 8-iteration shift-add multiply, writing results back with carry/zero flags.
module exec_unit #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [D-1:0] dst,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    output logic         busy,
    output logic         done,
    output logic         RegWrite,
    output logic [D-1:0] writeReg,
    output logic [W-1:0] writeValue,
    output logic         carry,
    output logic         zero
);

    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        MUL,
        WB_LO,
        WB_HI
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   dst_q, dst_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rw_q, rw_d;
    logic [D-1:0]   wreg_q, wreg_d;
    logic [W-1:0]   wval_q, wval_d;
    logic           done_q, done_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;

    logic [W-1:0]   alu_res;
    logic           alu_c;
    logic           alu_valid;
    logic [W:0]     sum;
    logic [2*W-1:0] sll_w;
    logic [2*W-1:0] srl_w;
    logic [CW-1:0]  sh;
    logic [2*W-1:0] prod_nxt;

    // Shifts run through a double-width window so the last bit shifted out
    // lands at a fixed position; a zero shift leaves that position clear.
    always_comb begin
        sh        = opB[CW-1:0];
        sum       = {1'b0, opA} + {1'b0, opB};
        sll_w     = {{W{1'b0}}, opA} << sh;
        srl_w     = {opA, {W{1'b0}}} >> sh;
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_valid = 1'b1;
        case (op)
            4'd0: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
            4'd1: begin
                alu_res = opA - opB;
                alu_c   = (opA >= opB);
            end
            4'd2: alu_res = opA & opB;
            4'd3: alu_res = opA | opB;
            4'd4: alu_res = opA ^ opB;
            4'd5: begin
                alu_res = sll_w[W-1:0];
                alu_c   = sll_w[W];
            end
            4'd6: begin
                alu_res = srl_w[2*W-1:W];
                alu_c   = srl_w[W-1];
            end
            default: alu_valid = 1'b0;
        endcase
    end

    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        rw_d     = 1'b0;
        wreg_d   = '0;
        wval_d   = '0;
        done_d   = 1'b0;
        carry_d  = carry_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dst_d = dst;
                    if (op == 4'd7) begin
                        state_d  = MUL;
                        mcand_d  = {{W{1'b0}}, opA};
                        mplier_d = opB;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d = WB;
                        done_d  = 1'b1;
                        if (alu_valid) begin
                            rw_d    = 1'b1;
                            wreg_d  = dst;
                            wval_d  = alu_res;
                            carry_d = alu_c;
                            zero_d  = (alu_res == '0);
                        end
                    end
                end
            end
            WB: state_d = IDLE;
            MUL: begin
                prod_d   = prod_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = WB_LO;
                    rw_d    = 1'b1;
                    wreg_d  = dst_q;
                    wval_d  = prod_nxt[W-1:0];
                end
            end
            WB_LO: begin
                state_d = WB_HI;
                rw_d    = 1'b1;
                wreg_d  = dst_q + D'(1);
                wval_d  = prod_q[2*W-1:W];
                done_d  = 1'b1;
                carry_d = (prod_q[2*W-1:W] != '0);
                zero_d  = (prod_q == '0);
            end
            WB_HI: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            dst_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            wreg_q   <= '0;
            wval_q   <= '0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            wreg_q   <= wreg_d;
            wval_q   <= wval_d;
            done_q   <= done_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign RegWrite   = rw_q;
    assign writeReg   = wreg_q;
    assign writeValue = wval_q;
    assign carry      = carry_q;
    assign zero       = zero_q;

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute/writeback stage directly downstream of the 16x8 register file.
- Consumes the two combinational read ports (A, B) on the cycle an operation is started.
- Computes an ALU result: single-cycle logic/arith/shift ops, or an iterative shift-add 8x8 multiply.
- Drives the register file's write port (RegWrite/writeReg/writeValue) and holds carry/zero flags.

Parameters:
- W, 8, datapath width; operand and write-value width.
- D, 4, register address width; 2**D registers.

Ports:
- CLK  input  1  clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- start  input  1  launch request; accepted only when busy=0
- op  input  4  operation code, sampled with start
- dst  input  D  destination register, sampled with start
- opA  input  W  operand A (register file read port A), sampled with start
- opB  input  W  operand B (register file read port B), sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on the final writeback cycle of an op
- RegWrite  output  1  register file write enable
- writeReg  output  D  register file write address
- writeValue  output  W  register file write data
- carry  output  1  carry flag, registered
- zero  output  1  zero flag, registered

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, flags 0, multiply accumulators 0; any in-flight write is abandoned.
- FSM states: IDLE, WB, MUL, WB_LO, WB_HI.
- IDLE:
  - start=1 latches op, dst, opA, opB.
  - op 7 -> MUL; any other op -> WB.
  - start while busy=1 is ignored; no queueing.
- Opcodes, result width W:
  - 0 ADD: A+B; carry = bit W.
  - 1 SUB: A-B mod 2**W; carry = (A>=B), i.e. no borrow.
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 SLL: A << B[2:0]; carry = last bit shifted out; shift 0 -> carry 0.
  - 6 SRL: A >> B[2:0]; carry rule as SLL.
  - 7 MUL: 2W-bit unsigned product.
  - 8-15 reserved.
- WB (1 cycle, then IDLE):
  - RegWrite=1, writeReg=dst, writeValue=result, done=1.
  - Flags update this cycle; zero = (result==0).
  - Reserved op: RegWrite=0, done=1, flags unchanged.
- MUL:
  - Exactly W iteration cycles, one multiplier bit per cycle, LSB first, add-and-shift into a 2W-bit product.
  - Then WB_LO.
- WB_LO: RegWrite=1, writeReg=dst, writeValue=product[W-1:0]; done=0.
- WB_HI: RegWrite=1, writeReg=(dst+1) mod 2**D, writeValue=product[2W-1:W], done=1; then IDLE.
  - Flags on WB_HI: zero = (product==0), carry = (product[2W-1:W]!=0).
- Latency from start (cycle 0):
  - Single-cycle ops: write and done in cycle 1; next start accepted in cycle 2.
  - MUL: iterations in cycles 1..8, WB_LO in cycle 9, WB_HI/done in cycle 10; next start accepted in cycle 11.
- RegWrite is asserted only in WB, WB_LO and WB_HI. writeReg/writeValue are 0 whenever RegWrite=0.
- Register-file write protection is not filtered here:
  - dst=14 still asserts RegWrite (the register file drops the write).
  - MUL with dst=15 writes high byte to address 0 (wrap).
- Operands are captured at start. Later changes on opA/opB/op/dst, including reg-file writes by this block, do not affect the op in flight.
- start held high continuously: re-accepted on the first cycle busy=0.

Test Plan:
- Reset, then ADD opA=0xF0 opB=0x20 dst=3 -> cycle 1: RegWrite=1 writeReg=3 writeValue=0x10 carry=1 zero=0 done=1; busy low in cycle 2.
- SUB opA=0x05 opB=0x05 dst=2 -> writeValue=0x00 zero=1 carry=1; then SUB 0x03-0x04 -> 0xFF carry=0 zero=0.
- SLL opA=0x81 opB=0x01 dst=1 -> writeValue=0x02 carry=1; SRL opA=0x81 opB=0x00 -> 0x81 carry=0.
- MUL opA=0xFF opB=0xFF dst=15 -> busy for 10 cycles; cycle 9 writes 0x01 to reg 15; cycle 10 writes 0xFE to reg 0 with done=1, carry=1, zero=0.
- MUL start, second start at cycle 4 (ignored), Reset pulsed at cycle 6 -> no RegWrite ever, all outputs 0, busy=0; fresh ADD afterwards completes normally.
- Reserved op 0xA with start -> done=1 in cycle 1, RegWrite=0, flags unchanged from prior op.
